// File: rtl/binary_2_gray_4bit.sv
// Binary-to-Gray converter with a registered Gray stage, a combinational
// Gray-to-binary decode of that stage, a single-bit-step flag and a sticky round-trip error flag.
module binary_2_gray_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] G_q,
  output logic [WIDTH-1:0] B_dec,
  output logic             step_ok,
  output logic             err
);

  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             step_ok_q, step_ok_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] gray_diff;
  logic             one_bit_change;
  logic             round_trip_bad;

  // Pure per-bit XOR, so an X/Z on one B bit only disturbs the G bits it feeds.
  assign G = B ^ (B >> 1);

  // Each decoded bit is the XOR of all Gray bits at or above it; writing it
  // this way avoids a bit-to-bit dependency chain inside one vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign B_dec[i] = ^gray_q[WIDTH-1:i];
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign gray_diff      = G ^ gray_q;
  assign one_bit_change = (gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0);

  // Compares the already-registered pair, so a mismatch is seen one cycle after the load.
  assign round_trip_bad = (B_dec != bin_q);

  // NOTE: every next-state signal gets a default before any condition, so no latch is inferred.
  always_comb begin
    gray_d    = G;
    bin_d     = B;
    step_ok_d = one_bit_change;
    err_d     = err_q | round_trip_bad;
  end

  // NOTE: state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q    <= '0;
      bin_q     <= '0;
      step_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      gray_q    <= gray_d;
      bin_q     <= bin_d;
      step_ok_q <= step_ok_d;
      err_q     <= err_d;
    end
  end

  assign G_q     = gray_q;
  assign step_ok = step_ok_q;
  assign err     = err_q;

endmodule

// File: tb/tb_binary_2_gray_4bit.sv
// Self-checking bench: a Gray-code reference table drives a combinational sweep;
// clocked sequences push expected results to a scoreboard queue that is popped after each edge.
module tb_binary_2_gray_4bit;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
  } vec_t;

  typedef struct packed {
    logic [3:0] g_q;
    logic [3:0] b_dec;
    logic       step_ok;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] B = '0;
  logic [3:0] G, G_q, B_dec;
  logic       step_ok, err;

  int checks = 0;
  int failures = 0;

  vec_t tbl[16];
  exp_t sb[$];
  logic [3:0] model_prev_g;

  binary_2_gray_4bit #(.WIDTH(4)) dut (
    .B       (B),
    .G       (G),
    .clk     (clk),
    .rst     (rst),
    .G_q     (G_q),
    .B_dec   (B_dec),
    .step_ok (step_ok),
    .err     (err)
  );

  // Clock stays low until enabled, so the first sweep runs with no edges at all.
  always #5 clk = clk_en & ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, push its expectation,
  // then pop and compare at the next falling edge.
  task automatic cycle(input logic [3:0] b, input logic r, input string tag);
    exp_t e;
    exp_t got;
    logic [3:0] g;
    B   = b;
    rst = r;
    if (r) begin
      e = '{g_q: 4'h0, b_dec: 4'h0, step_ok: 1'b0, err: 1'b0};
      model_prev_g = 4'h0;
    end else begin
      g = tbl[b].g;
      e.g_q     = g;
      e.b_dec   = b;
      e.step_ok = ($countones(g ^ model_prev_g) == 1);
      e.err     = 1'b0;
      model_prev_g = g;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    check($sformatf("%s G_q", tag),     {28'd0, G_q},     {28'd0, got.g_q});
    check($sformatf("%s B_dec", tag),   {28'd0, B_dec},   {28'd0, got.b_dec});
    check($sformatf("%s step_ok", tag), {31'd0, step_ok}, {31'd0, got.step_ok});
    check($sformatf("%s err", tag),     {31'd0, err},     {31'd0, got.err});
    check($sformatf("%s G", tag),       {28'd0, G},       {28'd0, tbl[b].g});
  endtask

  initial begin
    tbl[0]  = '{4'd0,  4'b0000}; tbl[1]  = '{4'd1,  4'b0001};
    tbl[2]  = '{4'd2,  4'b0011}; tbl[3]  = '{4'd3,  4'b0010};
    tbl[4]  = '{4'd4,  4'b0110}; tbl[5]  = '{4'd5,  4'b0111};
    tbl[6]  = '{4'd6,  4'b0101}; tbl[7]  = '{4'd7,  4'b0100};
    tbl[8]  = '{4'd8,  4'b1100}; tbl[9]  = '{4'd9,  4'b1101};
    tbl[10] = '{4'd10, 4'b1111}; tbl[11] = '{4'd11, 4'b1110};
    tbl[12] = '{4'd12, 4'b1010}; tbl[13] = '{4'd13, 4'b1011};
    tbl[14] = '{4'd14, 4'b1001}; tbl[15] = '{4'd15, 4'b1000};
    model_prev_g = 4'h0;

    // Combinational sweep with no clock running.
    for (int i = 0; i < 16; i++) begin
      B = tbl[i].b;
      #5;
      check($sformatf("sweep G[%0d]", i), {28'd0, G}, {28'd0, tbl[i].g});
    end

    // Reset held for two cycles with B=1010; G keeps converting throughout.
    clk_en = 1'b1;
    @(negedge clk);
    cycle(4'b1010, 1'b1, "reset0");
    cycle(4'b1010, 1'b1, "reset1");

    // Counting 0..15 then wrap to 0: every update is a single-bit step.
    for (int i = 0; i < 16; i++) cycle(i[3:0], 1'b0, $sformatf("count%0d", i));
    cycle(4'd0, 1'b0, "wrap");

    // Jump 0,2,2: distance 0, 2, 0 -- never a single-bit step, never an error.
    cycle(4'd0, 1'b0, "jump0");
    cycle(4'd2, 1'b0, "jump2");
    cycle(4'd2, 1'b0, "jump2b");

    // Mid-run reset at B=9, then B=10 lands four bits away from zero.
    for (int i = 0; i < 10; i++) cycle(i[3:0], 1'b0, $sformatf("run%0d", i));
    cycle(4'd9, 1'b1, "midrst");
    cycle(4'd10, 1'b0, "postrst");
    cycle(4'd11, 1'b0, "post11");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
